line_buffer_3row: RTL
=====================

# line_buffer_3row

Three-row line buffer that sits directly upstream of the 3x3 mean filter stage. It converts a raster-order 8-bit pixel stream into three vertically aligned pixels per column: the current row and the two rows above it. It drives the filter's `en`/`r0`/`r1`/`r2` inputs. It suppresses `en` until two full lines are buffered and restarts filling on every frame start.

## Interface
- `IMG_WIDTH`, 640, pixels per line (≥ 2).
- `IMG_HEIGHT`, 480, lines per frame (≥ 3).
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `sof`  in  1  start of frame, sampled only with `pix_valid`; marks the current pixel as row 0, col 0.
- `pix_valid`  in  1  `pix_in` carries a valid pixel this cycle.
- `pix_in`  in  8  raster-order pixel.
- `en`  out  1  `r0`/`r1`/`r2` hold a valid column triple this cycle.
- `r0`  out  8  pixel at (row y-2, col c).
- `r1`  out  8  pixel at (row y-1, col c).
- `r2`  out  8  pixel at (row y, col c), i.e. the input pixel.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Storage: two line memories `lineA` (row y-1) and `lineB` (row y-2), each `IMG_WIDTH` x 8, indexed by column counter `col`.
- Per accepted pixel (`pix_valid`=1), all actions take effect on the same edge:
  - Read `lineA[col]` and `lineB[col]` using read-before-write (old contents).
  - Register outputs: `r2`<=`pix_in`, `r1`<=old `lineA[col]`, `r0`<=old `lineB[col]`.
  - Write `lineB[col]`<=old `lineA[col]` and `lineA[col]`<=`pix_in`.
- Counters:
  - `col` is 0..`IMG_WIDTH`-1 and wraps to 0 after the last column; `row` increments on that wrap.
  - `row` is 0..`IMG_HEIGHT`-1 and wraps to 0 after the last column of the last row.
- FSM (advances only on accepted pixels):
  - FILL0 (row 0): `en` stays 0. Goes to FILL1 at the end of the line.
  - FILL1 (row 1): `en` stays 0. Goes to STREAM at the end of the line.
  - STREAM (rows 2..`IMG_HEIGHT`-1): `en` is 1 for each accepted pixel. After the last pixel of the frame, goes to FILL0 and pulses `frame_done`.
- `sof` with `pix_valid`:
  - Forces `col`=0, `row`=0 and state FILL0 before that pixel is processed.
  - The pixel is written as row 0, col 0 and `en` is 0 for it.
  - Valid at any point, including mid-frame (abort and refill) and on the same cycle as a natural frame wrap.
  - `sof` without `pix_valid` is ignored.
- `pix_valid`=0: counters, FSM and memories hold. `en` goes to 0 next cycle; `r0`/`r1`/`r2` hold their last values.
- Line memory contents are not reset. FILL states guarantee stale data is never presented with `en`=1.

## Timing
- Latency is 1 cycle from an accepted pixel to its `en`/`r*` outputs. Throughput is 1 pixel/cycle with no back-pressure.
- `en` is registered and equals the accepted pixel's qualification (`pix_valid` and state STREAM after any `sof` override).
- `frame_done` is registered and asserts in the same cycle as the `en` for the frame's last pixel.
- Reset values: `en`=0, `r0`=`r1`=`r2`=0, `frame_done`=0, `col`=0, `row`=0, state FILL0.
- `rst` asserted mid-frame: all outputs clear immediately. The first accepted pixel after release is row 0 whether or not `sof` is asserted.
- Gaps in `pix_valid` are allowed anywhere, including across line and frame boundaries, with no effect on alignment.

## Test plan
All scenarios use `IMG_WIDTH`=4, `IMG_HEIGHT`=4 and pixel value = 16*row + col.
1. **Reset:** assert `rst` while driving `pix_valid`=1, `pix_in`=0xFF -> `en`=0, `r0`/`r1`/`r2`=0, `frame_done`=0 throughout and immediately on assertion.
2. **Fill and stream:** drive `sof` with 0x00, then 15 more pixels back-to-back.
   - `en`=0 for the first 8 output cycles.
   - Cycle after 0x20: `en`=1, `r0`=0x00, `r1`=0x10, `r2`=0x20.
   - Cycle after 0x33: `r0`=0x13, `r1`=0x23, `r2`=0x33, `frame_done`=1 for exactly one cycle.
3. **Gaps:** repeat scenario 2 with `pix_valid` toggling 1,0 -> identical triples in the same order; `en`=0 in every gap cycle; `r*` hold during gaps.
4. **Back-to-back frames:** after frame 1, send frame 2 with pixel value = 0x80 + 16*row + col, no `sof` -> first `en`=1 triple is 0x80/0x90/0xA0. No frame-1 data ever appears with `en`=1.
5. **Mid-frame `sof`:** during row 2 col 1, assert `sof` with pixel 0xAA, then continue the stream -> `en`=0 for that pixel and the next 7. The first `en`=1 triple uses rows from the new frame only.
6. **Reset mid-operation:** pulse `rst` at row 3 col 2, then stream without `sof` -> outputs clear at once. `en` first rises 1 cycle after the 9th pixel accepted post-reset.

Source files
------------

// File: rtl/line_buffer_3row.sv
// Three-row line buffer: raster 8-bit pixels in, vertically aligned column triples out.
// Latency: 1 cycle from accepted pixel to en/r0/r1/r2; frame_done aligned with the last pixel's en.
// Backpressure: none; accepts one pixel per cycle whenever i_pix_valid is high.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_sof               start of frame (only honoured together with i_pix_valid)
//   i_pix_valid         i_pix_in carries a pixel this cycle
//   i_pix_in[7:0]       raster-order pixel
//   o_en                o_r0/o_r1/o_r2 hold a valid column triple
//   o_r0/o_r1/o_r2      pixels at rows y-2 / y-1 / y of the same column
//   o_frame_done        one-cycle pulse with the last pixel of a frame
module line_buffer_3row #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sof,
  input  logic       i_pix_valid,
  input  logic [7:0] i_pix_in,
  output logic       o_en,
  output logic [7:0] o_r0,
  output logic [7:0] o_r1,
  output logic [7:0] o_r2,
  output logic       o_frame_done
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    FILL0  = 2'd0,
    FILL1  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // lineA holds row y-1, lineB holds row y-2; contents are never reset.
  logic [7:0] r_linea [0:IMG_WIDTH-1];
  logic [7:0] r_lineb [0:IMG_WIDTH-1];

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_en;
  logic          r_frame_done;
  logic [7:0]    r_r0;
  logic [7:0]    r_r1;
  logic [7:0]    r_r2;

  // Effective position/state for the pixel on the bus: sof overrides the
  // stored counters before the pixel is processed.
  logic          w_restart;
  state_t        w_state;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_last_col;
  logic          w_last_row;
  logic [7:0]    w_old_a;
  logic [7:0]    w_old_b;

  always_comb begin
    w_restart  = i_pix_valid & i_sof;
    w_state    = w_restart ? FILL0 : r_state;
    w_col      = w_restart ? '0 : r_col;
    w_row      = w_restart ? '0 : r_row;
    w_last_col = (w_col == LAST_COL);
    w_last_row = (w_row == LAST_ROW);
    w_old_a    = r_linea[w_col];
    w_old_b    = r_lineb[w_col];
  end

  // Line memories: read-before-write, lineA's old pixel shifts down into lineB.
  always_ff @(posedge i_clk) begin
    if (i_pix_valid) begin
      r_lineb[w_col] <= w_old_a;
      r_linea[w_col] <= i_pix_in;
    end
  end

  // Counters, fill/stream FSM and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= FILL0;
      r_col        <= '0;
      r_row        <= '0;
      r_en         <= 1'b0;
      r_frame_done <= 1'b0;
      r_r0         <= '0;
      r_r1         <= '0;
      r_r2         <= '0;
    end else if (i_pix_valid) begin
      r_r2         <= i_pix_in;
      r_r1         <= w_old_a;
      r_r0         <= w_old_b;
      r_en         <= (w_state == STREAM);
      r_frame_done <= (w_state == STREAM) && w_last_col && w_last_row;

      r_col <= w_last_col ? '0 : w_col + CW'(1);
      if (w_last_col) begin
        r_row <= w_last_row ? '0 : w_row + RW'(1);
      end else begin
        r_row <= w_row;
      end

      case (w_state)
        FILL0:   r_state <= w_last_col ? FILL1 : FILL0;
        FILL1:   r_state <= w_last_col ? STREAM : FILL1;
        STREAM:  r_state <= (w_last_col && w_last_row) ? FILL0 : STREAM;
        default: r_state <= FILL0;
      endcase
    end else begin
      // Idle cycle: position and data hold, qualifiers drop.
      r_en         <= 1'b0;
      r_frame_done <= 1'b0;
    end
  end

  assign o_en         = r_en;
  assign o_frame_done = r_frame_done;
  assign o_r0         = r_r0;
  assign o_r1         = r_r1;
  assign o_r2         = r_r2;

endmodule
